// File: rtl/key_hash_unit_if.sv
// -----------------------------------------------------------------------------
// key_hash_unit_if
// Purpose : groups the start/done handshake, the key/amount operands, the
//           288-bit random table and the hash results of key_hash_unit.
// Signals :
//   start        1   request a hash (controller -> hash unit)
//   key_in       8   key operand, captured on accepted start
//   amount_in    8   amount operand, captured on accepted start
//   random_table 288 chunk_1 at [287:256] ... chunk_8 at [63:32],
//                    buffer_chunk at [31:0]; held stable while busy
//   busy         1   hash in progress
//   done         1   one-cycle pulse, digest valid
//   digest       8   hash result, held until next accepted start or reset
//   round_idx    3   current 0-based round number (debug)
// Modports: master = transaction controller, slave = key_hash_unit.
// -----------------------------------------------------------------------------
interface key_hash_unit_if;
  logic         start;
  logic [7:0]   key_in;
  logic [7:0]   amount_in;
  logic [287:0] random_table;
  logic         busy;
  logic         done;
  logic [7:0]   digest;
  logic [2:0]   round_idx;

  modport master (
    output start, key_in, amount_in, random_table,
    input  busy, done, digest, round_idx
  );

  modport slave (
    input  start, key_in, amount_in, random_table,
    output busy, done, digest, round_idx
  );
endinterface

// File: rtl/key_hash_unit.sv
// -----------------------------------------------------------------------------
// key_hash_unit
// Purpose : multi-cycle hash of an 8-bit key and 8-bit amount against a
//           288-bit random table, one chunk round per cycle, producing an
//           8-bit digest for the downstream verify datapath.
// Ports   :
//   clock   in   system clock, rising edge
//   reset   in   synchronous active-high reset
//   bus     slave modport of key_hash_unit_if (start/key_in/amount_in/
//           random_table in; busy/done/digest/round_idx out)
// Params  : NUM_ROUNDS (1..8) chunk rounds, ROT (0..7) left-rotate per round.
// Option  : KEY_HASH_CHAIN_EN - when defined, the previous digest is folded
//           into the initial accumulator so successive hashes are chained.
// Timing  : start accepted at edge E -> done high in the cycle after edge
//           E+NUM_ROUNDS+1. done and digest are registered on the last round
//           edge so they are valid together during the FINISH cycle.
// -----------------------------------------------------------------------------
module key_hash_unit #(
  parameter int NUM_ROUNDS = 8,
  parameter int ROT        = 3
) (
  input  logic            clock,
  input  logic            reset,
  key_hash_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_FINISH} state_t;

  state_t     r_state, w_state_next;
  logic [7:0] r_key, w_key_next;
  logic [7:0] r_amount, w_amount_next;
  logic [7:0] r_acc, w_acc_next;
  logic [7:0] r_digest, w_digest_next;
  logic       r_busy, w_busy_next;
  logic       r_done, w_done_next;
  logic [2:0] r_round_idx, w_round_idx_next;

  // Only the low 16 bits of each chunk take part in a round.
  logic [15:0] w_chunk_lo [8];
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_chunk
      assign w_chunk_lo[gi] = bus.random_table[271 - 32*gi -: 16];
    end
  endgenerate

  logic [15:0] w_cur_chunk;
  logic [7:0]  w_round_acc;
  logic [7:0]  w_final_digest;
  logic [7:0]  w_load_acc;

  function automatic logic [7:0] rotl(input logic [7:0] v);
    logic [15:0] d;
    d = {v, v} << ROT;
    return d[15:8];
  endfunction

  assign w_cur_chunk = w_chunk_lo[r_round_idx];
  // 8-bit result drops the carry of the addition.
  assign w_round_acc = (rotl(r_acc) ^ w_cur_chunk[7:0]) + (w_cur_chunk[15:8] ^ r_key);
  assign w_final_digest = w_round_acc ^ bus.random_table[7:0] ^ bus.random_table[21:14];

`ifdef KEY_HASH_CHAIN_EN
  logic [7:0] r_prev_digest;
  always_ff @(posedge clock) begin
    if (reset)
      r_prev_digest <= 8'h00;
    else if (w_done_next)
      r_prev_digest <= w_final_digest;
  end
  assign w_load_acc = r_key ^ r_amount ^ r_prev_digest;
`else
  assign w_load_acc = r_key ^ r_amount;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_key       <= 8'h00;
      r_amount    <= 8'h00;
      r_acc       <= 8'h00;
      r_digest    <= 8'h00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_round_idx <= 3'd0;
    end else begin
      r_state     <= w_state_next;
      r_key       <= w_key_next;
      r_amount    <= w_amount_next;
      r_acc       <= w_acc_next;
      r_digest    <= w_digest_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_round_idx <= w_round_idx_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_key_next       = r_key;
    w_amount_next    = r_amount;
    w_acc_next       = r_acc;
    w_digest_next    = r_digest;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_round_idx_next = r_round_idx;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_key_next    = bus.key_in;
          w_amount_next = bus.amount_in;
          w_busy_next   = 1'b1;
          w_state_next  = S_LOAD;
        end
      end
      S_LOAD: begin
        w_acc_next       = w_load_acc;
        w_round_idx_next = 3'd0;
        w_state_next     = S_ROUND;
      end
      S_ROUND: begin
        w_acc_next = w_round_acc;
        if (r_round_idx == 3'(NUM_ROUNDS - 1)) begin
          // Raise done with the final digest; round_idx keeps its last value.
          w_digest_next = w_final_digest;
          w_done_next   = 1'b1;
          w_busy_next   = 1'b0;
          w_state_next  = S_FINISH;
        end else begin
          w_round_idx_next = r_round_idx + 3'd1;
        end
      end
      S_FINISH: begin
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.digest    = r_digest;
  assign bus.round_idx = r_round_idx;

endmodule

// File: doc/key_hash_unit.md
Name: key_hash_unit

Overview:
- Multi-cycle hashing stage that sits directly upstream of verify_datapath.
- Takes the latched 8-bit key and 8-bit amount from the switch inputs and folds them, one round per cycle, against the 288-bit random_table (eight 32-bit chunks plus a buffer chunk).
- Produces an 8-bit digest, which verify_datapath compares against memory contents.
- Start/done handshake with the transaction controller.

Parameters:
- NUM_ROUNDS, 8, number of chunk rounds; legal range 1..8; round r uses chunk r+1.
- ROT, 3, left-rotate amount applied to the accumulator each round; legal range 0..7.

Ports:
- clock  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a hash; sampled only in IDLE.
- key_in  input  8  key value, captured on accepted start.
- amount_in  input  8  amount value, captured on accepted start.
- random_table  input  288  chunk_1 at [287:256] … chunk_8 at [63:32], buffer_chunk at [31:0]; must be stable while busy.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when digest is valid.
- digest  output  8  hash result; holds until the next accepted start or reset.
- round_idx  output  3  current round number (0-based) for debug/animation.

Behaviour:
- Reset (synchronous, active-high, on a clock edge with reset=1):
  - state=IDLE; busy=0, done=0, digest=8'h00, round_idx=0.
  - Internal key_r, amount_r and acc cleared to 0.
- Reset has priority over every other event, including mid-hash: the hash is abandoned, no done pulse is issued, and digest is cleared.
- State machine IDLE -> LOAD -> ROUND -> FINISH -> IDLE:
  - IDLE: on start=1, capture key_r=key_in and amount_r=amount_in, then go to LOAD. start=0: remain.
  - LOAD (1 cycle): acc = key_r ^ amount_r; round_idx=0; busy=1.
  - ROUND (NUM_ROUNDS cycles):
    - chunk = 32-bit slice for round_idx.
    - acc_next = (rotl(acc,ROT) ^ chunk[7:0]) + (chunk[15:8] ^ key_r), all mod 256 (carry discarded).
    - round_idx increments each cycle; after round NUM_ROUNDS-1, go to FINISH.
  - FINISH (1 cycle):
    - digest = acc ^ buffer_chunk[7:0] ^ buffer_chunk[21:14].
    - done=1 for exactly this cycle; busy=0 at the same edge that raises done.
    - Return to IDLE.
- Latency, with start sampled at edge E: done is high in the cycle following edge E+NUM_ROUNDS+1, which is 10 cycles for the default.
- start while busy or in FINISH is ignored; no queuing.
- start held high continuously re-triggers on the first IDLE cycle after FINISH, so back-to-back hashes have a 1-cycle IDLE gap minimum.
- Chunk bits [31:22] are unused by the hash.
- round_idx holds its last value in FINISH and IDLE until the next LOAD.
- digest does not change during ROUND; it is updated only in FINISH.

Optional Feature:
- Macro: KEY_HASH_CHAIN_EN.
- Defined:
  - LOAD computes acc = key_r ^ amount_r ^ prev_digest.
  - prev_digest is an internal register loaded with digest at each FINISH and cleared by reset.
  - Successive transactions are therefore chained.
- Undefined:
  - No prev_digest register exists.
  - LOAD uses key_r ^ amount_r only.
  - Each hash is independent.

Test Plan:
- Reset hold: reset=1 for 2 cycles -> busy=0, done=0, digest=8'h00, round_idx=0.
- Zero table, key_in=8'h00, amount_in=8'h00, start pulse -> done pulse exactly 10 cycles later; digest=8'h00; busy high for the 9 cycles preceding done.
- Zero table, key_in=8'h00, amount_in=8'h01 -> eight rotate-by-3 steps give rotate-by-24, so digest=8'h01.
- Zero table, key_in=8'h00, amount_in=8'h01; start asserted again in cycles 3 and 6 -> ignored; exactly one done pulse; digest=8'h01.
- Zero table; assert reset during round 4 -> next cycle busy=0, digest=8'h00, no done pulse; a following start with key=0, amount=1 gives digest=8'h01 (with KEY_HASH_CHAIN_EN as well).
- KEY_HASH_CHAIN_EN defined, zero table, two hashes of key=0, amount=1 -> first digest=8'h01; second acc0 = 1^1 = 0, so digest=8'h00.
